// File: rtl/hex_digit_entry_pkg.sv
// Shared definitions for the push-button hex entry front end: button indices,
// default timing constants, the decoded user action and a counter sizing helper.
package hex_digit_entry_pkg;

   localparam int unsigned NUM_BUTTONS = 4;

   localparam int unsigned BTN_INC   = 0;
   localparam int unsigned BTN_DEC   = 1;
   localparam int unsigned BTN_LEFT  = 2;
   localparam int unsigned BTN_RIGHT = 3;

   // 10 ms debounce and 250 ms auto-repeat at 50 MHz
   localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;
   localparam int unsigned DEFAULT_REPEAT_CYCLES   = 12500000;

   typedef enum logic [2:0] {
      ACT_NONE,
      ACT_INC,
      ACT_DEC,
      ACT_LEFT,
      ACT_RIGHT
   } action_e;

   // Bits needed to count up to max(a, b) - 1
   function automatic int unsigned counter_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/hex_digit_entry_button_debouncer.sv
// One push-button channel: 2-FF synchronizer, stable-level debounce counter,
// rising-edge press pulse and an optional hold-to-repeat pulse generator.
import hex_digit_entry_pkg::*;

module button_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int unsigned REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES,
   parameter bit          REPEAT_EN       = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic level,
   output logic press
);

   localparam int unsigned CNT_W = counter_width(DEBOUNCE_CYCLES, REPEAT_CYCLES);
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic [CNT_W-1:0] r_db_cnt;
   logic             r_level;
   logic             r_press;
   logic             w_rpt_hit;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_db_cnt <= '0;
         r_level  <= 1'b0;
         r_press  <= 1'b0;
      end else begin
         r_sync1 <= btn;
         r_sync2 <= r_sync1;
         r_press <= w_rpt_hit;
         // Any sample matching the accepted level restarts the stability window
         if (r_sync2 == r_level) begin
            r_db_cnt <= '0;
         end else if (r_db_cnt == DB_LAST) begin
            r_db_cnt <= '0;
            r_level  <= r_sync2;
            if (r_sync2) begin
               r_press <= 1'b1;
            end
         end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
         end
      end
   end

   generate
      if (REPEAT_EN) begin : g_repeat
         logic [CNT_W-1:0] r_rpt_cnt;

         // Counter is held at zero on the accept edge, so the first repeat
         // lands exactly REPEAT_CYCLES after the initial press pulse.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               r_rpt_cnt <= '0;
            end else if (!r_level || (r_rpt_cnt == RP_LAST)) begin
               r_rpt_cnt <= '0;
            end else begin
               r_rpt_cnt <= r_rpt_cnt + 1'b1;
            end
         end

         assign w_rpt_hit = r_level && (r_rpt_cnt == RP_LAST);
      end else begin : g_no_repeat
         assign w_rpt_hit = 1'b0;
      end
   endgenerate

   assign level = r_level;
   assign press = r_press;

endmodule

// File: rtl/hex_digit_entry.sv
// Four debounced buttons edit a DIGITS-digit hex value one nibble at a time;
// the cursor is one-hot and `changed` pulses whenever the value is edited.
import hex_digit_entry_pkg::*;

module hex_digit_entry #(
   parameter int unsigned DIGITS          = 4,
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int unsigned REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [3:0]            btn,
   output logic [DIGITS*4-1:0]   number,
   output logic [DIGITS-1:0]     cursor,
   output logic                  changed
);

   logic [NUM_BUTTONS-1:0] w_press;
   logic [DIGITS*4-1:0]    r_number;
   logic [DIGITS-1:0]      r_cursor;
   logic                   r_changed;
   logic [DIGITS*4-1:0]    w_number_step;
   logic [DIGITS-1:0]      w_cursor_left;
   logic [DIGITS-1:0]      w_cursor_right;
   action_e                w_action;

   button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .REPEAT_EN       (1'b1)
   ) u_btn_inc (
      .clk   (clk),
      .reset (reset),
      .btn   (btn[BTN_INC]),
      .level (),
      .press (w_press[BTN_INC])
   );

   button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .REPEAT_EN       (1'b1)
   ) u_btn_dec (
      .clk   (clk),
      .reset (reset),
      .btn   (btn[BTN_DEC]),
      .level (),
      .press (w_press[BTN_DEC])
   );

   button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .REPEAT_EN       (1'b0)
   ) u_btn_left (
      .clk   (clk),
      .reset (reset),
      .btn   (btn[BTN_LEFT]),
      .level (),
      .press (w_press[BTN_LEFT])
   );

   button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .REPEAT_EN       (1'b0)
   ) u_btn_right (
      .clk   (clk),
      .reset (reset),
      .btn   (btn[BTN_RIGHT]),
      .level (),
      .press (w_press[BTN_RIGHT])
   );

   // Lower button index wins; losing pulses in the same cycle are discarded
   always_comb begin
      w_action = ACT_NONE;
      if (w_press[BTN_INC]) begin
         w_action = ACT_INC;
      end else if (w_press[BTN_DEC]) begin
         w_action = ACT_DEC;
      end else if (w_press[BTN_LEFT]) begin
         w_action = ACT_LEFT;
      end else if (w_press[BTN_RIGHT]) begin
         w_action = ACT_RIGHT;
      end
   end

   always_comb begin
      w_number_step = r_number;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         if (r_cursor[k]) begin
            if (w_action == ACT_DEC) begin
               w_number_step[4*k +: 4] = r_number[4*k +: 4] - 4'd1;
            end else begin
               w_number_step[4*k +: 4] = r_number[4*k +: 4] + 4'd1;
            end
         end
      end
   end

   // Modulo indexing keeps the rotation valid for any DIGITS, including 1
   always_comb begin
      w_cursor_left  = '0;
      w_cursor_right = '0;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         w_cursor_left[(k + 1) % DIGITS] = r_cursor[k];
         w_cursor_right[k]               = r_cursor[(k + 1) % DIGITS];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_number  <= '0;
         r_cursor  <= DIGITS'(1);
         r_changed <= 1'b0;
      end else begin
         r_changed <= 1'b0;
         unique case (w_action)
            ACT_INC, ACT_DEC: begin
               r_number  <= w_number_step;
               r_changed <= 1'b1;
            end
            ACT_LEFT:  r_cursor <= w_cursor_left;
            ACT_RIGHT: r_cursor <= w_cursor_right;
            default: ;
         endcase
      end
   end

   assign number  = r_number;
   assign cursor  = r_cursor;
   assign changed = r_changed;

endmodule
